// File: rtl/mux_sched_pkg.sv
// Shared types and helpers for the round-robin mux scheduler.
package mux_sched_pkg;

    localparam int N_REQ_DEF     = 16;
    localparam int SEL_W_DEF     = 4;
    localparam int MAX_BURST_DEF = 4;
    localparam int MAX_N         = 32;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    // First set bit searching ptr+1, ptr+2, ... mod n; -1 if none.
    function automatic int rr_first(
        input logic [MAX_N-1:0] req,
        input int               ptr,
        input int               n
    );
        int r;
        int c;
        r = -1;
        for (int k = MAX_N; k >= 1; k--) begin
            if (k <= n) begin
                c = (ptr + k) & (n - 1);
                if (req[c]) r = c;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_rr_pick.sv
// Rotating-priority encoder: lowest offset above ptr wins.
module mux_rr_pick
    import mux_sched_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int SEL_W = SEL_W_DEF
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [SEL_W-1:0] i_ptr,
    output logic [SEL_W-1:0] o_idx,
    output logic             o_found
);

    int w_res;

    always_comb begin
        w_res   = rr_first(MAX_N'(i_req), int'(i_ptr), N_REQ);
        o_found = (w_res >= 0);
        o_idx   = SEL_W'(w_res);
    end

endmodule

// File: rtl/mux_rr_sched.sv
// Round-robin scheduler driving the 16:1 mux selects and a
// valid/ready output; bursts of up to MAX_BURST beats per grant.
module mux_rr_sched
    import mux_sched_pkg::*;
#(
    parameter int N_REQ     = N_REQ_DEF,
    parameter int SEL_W     = SEL_W_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             out_ready,
    output logic [N_REQ-1:0] grant,
    output logic             ctrl0,
    output logic             ctrl1,
    output logic             ctrl2,
    output logic             ctrl3,
    output logic             out_valid,
    output logic             busy
);

    localparam int CNT_W = $clog2(MAX_BURST) + 1;

    state_t           r_state;
    logic [SEL_W-1:0] r_sel;
    logic [SEL_W-1:0] r_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic [N_REQ-1:0] r_grant;
    logic             r_valid;
    logic             r_busy;

    logic [SEL_W-1:0] w_idx;
    logic             w_found;
    logic             w_last;
    logic             w_rel;

    mux_rr_pick #(
        .N_REQ (N_REQ),
        .SEL_W (SEL_W)
    ) u_pick (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_idx   (w_idx),
        .o_found (w_found)
    );

    // out_valid is always high in XFER, so a beat is just out_ready.
    assign w_last = (r_cnt == CNT_W'(MAX_BURST - 1));
    assign w_rel  = !req[r_sel] || (out_ready && w_last);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_sel   <= '0;
            r_ptr   <= SEL_W'(N_REQ - 1);
            r_cnt   <= '0;
            r_grant <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_state <= XFER;
                        r_sel   <= w_idx;
                        r_grant <= N_REQ'(1) << w_idx;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                    end
                end
                XFER: begin
                    if (w_rel) begin
                        r_state <= IDLE;
                        r_grant <= '0;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_ptr   <= r_sel;
                        r_cnt   <= '0;
                    end else if (out_ready) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign grant     = r_grant;
    assign out_valid = r_valid;
    assign busy      = r_busy;
    assign ctrl0     = r_sel[3];
    assign ctrl1     = r_sel[2];
    assign ctrl2     = r_sel[1];
    assign ctrl3     = r_sel[0];

endmodule
